// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed, round-robin and XOR-join selection.
// One registered output stage gives one cycle of latency at full throughput.
module stream_mux_rr #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [CH_W-1:0]         sel,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch
);

    localparam logic [1:0] MODE_RR  = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;

    logic                 vld_p1;
    logic [WIDTH-1:0]     data_p1;
    logic [CH_W-1:0]      ch_p1;
    logic [CH_W-1:0]      last_p1;

    logic                 load_en;
    logic [N_CH-1:0]      grant;
    logic [CH_W-1:0]      grant_idx;
    logic                 found;
    logic [CH_W-1:0]      scan_idx;
    logic                 xfer;
    logic [WIDTH-1:0]     next_data;

    function automatic logic [WIDTH-1:0] xor_join(input logic [N_CH*WIDTH-1:0] d);
        logic [WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_CH; i++) begin
            acc = acc ^ d[i*WIDTH +: WIDTH];
        end
        return acc;
    endfunction

    // Stage p0: grant selection and input handshake
    assign load_en = !vld_p1 || out_ready;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = '0;
        case (mode)
            MODE_RR: begin
                // Scan starts just after the last served channel and wraps.
                for (int k = 1; k <= N_CH; k++) begin
                    scan_idx = CH_W'((int'(last_p1) + k) % N_CH);
                    if (!found && in_valid[scan_idx]) begin
                        found     = 1'b1;
                        grant_idx = scan_idx;
                    end
                end
                if (found) begin
                    grant[grant_idx] = 1'b1;
                end
            end
            MODE_XOR: begin
                if (&in_valid) begin
                    grant = '1;
                end
            end
            default: begin
                grant_idx = sel;
                if (int'(sel) < N_CH) begin
                    grant[sel] = 1'b1;
                end
            end
        endcase
    end

    assign in_ready  = (load_en && !rst) ? grant : '0;
    assign xfer      = |(in_valid & in_ready);
    assign next_data = (mode == MODE_XOR) ? xor_join(in_data)
                                          : in_data[int'(grant_idx)*WIDTH +: WIDTH];

    // Stage p1: output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            last_p1 <= CH_W'(N_CH - 1);
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= next_data;
            ch_p1   <= (mode == MODE_XOR) ? '0 : grant_idx;
            if (mode == MODE_RR) begin
                last_p1 <= grant_idx;
            end
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transfer-level reference model.
module tb_stream_mux_rr;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int CW   = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     mode;
    logic [CW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    stream_mux_rr #(.N_CH(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: output register contents and the last channel served in round-robin.
    bit         m_vld;
    logic [7:0] m_data;
    int         m_ch;
    int         m_last;

    always @(negedge clk) begin
        bit         load;
        int         g;
        logic [3:0] exp_rdy;
        logic [7:0] word;
        load    = !m_vld || out_ready;
        g       = -1;
        exp_rdy = '0;
        if (!rst && load) begin
            if (mode == 2'd1) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && in_valid[(m_last + k) % N]) g = (m_last + k) % N;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end else if (mode == 2'd2) begin
                if (in_valid == 4'hF) exp_rdy = 4'hF;
            end else begin
                g = int'(sel);
                exp_rdy[g] = 1'b1;
            end
        end
        if (chk_en) begin
            check("in_ready",  32'(in_ready),  32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(m_vld));
            check("out_data",  32'(out_data),  32'(m_data));
            check("out_ch",    32'(out_ch),    32'(m_ch));
        end
        if (rst) begin
            m_vld = 0; m_data = '0; m_ch = 0; m_last = N - 1;
        end else if ((in_valid & exp_rdy) != 0) begin
            if (mode == 2'd2) begin
                word = '0;
                for (int i = 0; i < N; i++) word = word ^ in_data[i*W +: W];
                m_data = word;
                m_ch   = 0;
            end else begin
                m_data = in_data[g*W +: W];
                m_ch   = g;
                if (mode == 2'd1) m_last = g;
            end
            m_vld = 1;
        end else if (out_ready) begin
            m_vld = 0;
        end
    end

    task automatic step(input logic r, input logic [1:0] m, input logic [1:0] s,
                        input logic [3:0] v, input logic [31:0] d, input logic ordy);
        rst = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] SEQ = 32'h13121110;

    initial begin
        int rr_exp[7];
        rr_exp = '{1, 2, 3, 0, 1, 2, 3};
        rst = 1; mode = 0; sel = 0; in_valid = '1; in_data = SEQ; out_ready = 1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset with every channel valid
        step(1, 2'd1, 2'd0, 4'hF, SEQ, 1);
        step(1, 2'd1, 2'd0, 4'hF, SEQ, 1);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);

        // Round-robin fairness
        step(0, 2'd1, 2'd0, 4'hF, SEQ, 1);
        check("rr_first_ch", 32'(out_ch), 32'h0);
        check("rr_first_valid", 32'(out_valid), 32'h1);
        for (int i = 0; i < 7; i++) begin
            step(0, 2'd1, 2'd0, 4'hF, SEQ, 1);
            check("rr_seq_ch", 32'(out_ch), 32'(rr_exp[i]));
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 2'd1, 2'd0, 4'b1010, SEQ, 1);
            check("rr_alt_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Fixed select
        for (int i = 0; i < 3; i++) begin
            step(0, 2'd0, 2'd2, 4'hF, SEQ, 1);
            check("fix_data", 32'(out_data), 32'h12);
            check("fix_ch", 32'(out_ch), 32'h2);
            check("fix_ready", 32'(in_ready), 32'b0100);
        end

        // Backpressure: pointer sits at 3, so loads resume 0 then 1
        step(0, 2'd1, 2'd0, 4'hF, SEQ, 1);
        check("bp_load_ch", 32'(out_ch), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'd1, 2'd0, 4'hF, SEQ, 0);
            check("bp_hold_ch", 32'(out_ch), 32'h0);
            check("bp_hold_data", 32'(out_data), 32'h10);
            check("bp_ready", 32'(in_ready), 32'h0);
        end
        step(0, 2'd1, 2'd0, 4'hF, SEQ, 1);
        check("bp_resume_ch", 32'(out_ch), 32'h1);
        check("bp_resume_data", 32'(out_data), 32'h11);

        // XOR-join
        step(0, 2'd2, 2'd0, 4'b0111, 32'h33F00FA5, 1);
        step(0, 2'd2, 2'd0, 4'b0111, 32'h33F00FA5, 1);
        check("xor_partial_valid", 32'(out_valid), 32'h0);
        check("xor_partial_ready", 32'(in_ready), 32'h0);
        step(0, 2'd2, 2'd0, 4'hF, 32'h33F00FA5, 1);
        check("xor_data", 32'(out_data), 32'h69);
        check("xor_ch", 32'(out_ch), 32'h0);
        check("xor_valid", 32'(out_valid), 32'h1);

        // Reset while holding a word
        step(0, 2'd0, 2'd2, 4'hF, SEQ, 1);
        step(0, 2'd0, 2'd2, 4'hF, SEQ, 0);
        check("mid_hold_data", 32'(out_data), 32'h12);
        step(1, 2'd0, 2'd2, 4'hF, SEQ, 0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_data", 32'(out_data), 32'h0);
        step(0, 2'd1, 2'd0, 4'hF, SEQ, 1);
        check("mid_rr_ch", 32'(out_ch), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
